// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART blocks: parity mode codes, the serialiser
// FSM state encoding and the default bit period for the 100 MHz board clock.
// No ports; import with "import uart_pkg::*;".
package uart_pkg;

  // Parity mode codes used for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Serialiser FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    PAR   = ST_PAR,
    STOP  = ST_STOP
  } txState_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered pointers and occupancy count. Writes
// while full are dropped and latch a sticky overflow flag. The head entry is
// always visible on o_data so a reader can pop and use it in the same cycle.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset (clears pointers, count, overflow)
//   i_push     - write i_data this cycle (ignored when full)
//   i_data     - data to write
//   i_pop      - discard the head entry this cycle (ignored when empty)
//   o_data     - current head entry
//   o_full     - FIFO holds DEPTH entries
//   o_empty    - FIFO holds 0 entries
//   o_count    - current occupancy
//   o_overflow - sticky: a push was dropped since the last reset
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_doPush;
  logic w_doPop;

  // Full/empty come from the pre-edge count, so a push while full is
  // dropped even if a pop happens on the same edge.
  assign w_full   = (r_count == FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign w_doPush = i_push && !w_full;
  assign w_doPop  = i_pop && !w_empty;

  // Storage array carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_data     = r_mem[r_rdPtr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// FIFO-buffered UART transmitter. Bytes are pushed into a sync_fifo without
// back-pressure; the serialiser pops them and sends start, LSB-first data,
// optional parity and stop bits, chaining frames with no idle gap while the
// FIFO has data.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset; aborts any frame, flushes FIFO
//   wr_en    - push wr_data into the FIFO this cycle
//   wr_data  - payload to transmit
//   full     - FIFO holds FIFO_DEPTH entries
//   empty    - FIFO holds 0 entries
//   count    - FIFO occupancy
//   overflow - sticky: a write was dropped because the FIFO was full
//   busy     - serialiser is not idle
//   UART_TX  - registered serial line, idles high
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          UART_TX
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  localparam bit HAS_PARITY    = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam bit PARITY_INVERT = (PARITY == PAR_ODD);

  txState_t               r_state;
  logic [BAUD_W-1:0]      r_baud;
  logic [IDX_W-1:0]       r_bitIdx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;
  logic                   r_tx;

  txState_t               w_stateNext;
  logic [BAUD_W-1:0]      w_baudNext;
  logic [IDX_W-1:0]       w_bitIdxNext;
  logic [DATA_BITS-1:0]   w_shiftNext;
  logic                   w_parityNext;
  logic                   w_txNext;
  logic                   w_pop;
  logic                   w_baudDone;
  logic                   w_empty;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_headParity;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (wr_en),
    .i_data     (wr_data),
    .i_pop      (w_pop),
    .o_data     (w_head),
    .o_full     (full),
    .o_empty    (w_empty),
    .o_count    (count),
    .o_overflow (overflow)
  );

  assign w_baudDone   = (r_baud == BAUD_LAST);
  // Parity is fixed at pop time from the untouched payload.
  assign w_headParity = (^w_head) ^ PARITY_INVERT;

  // Next-state logic. r_tx is the registered line, so every transition sets
  // the line value for the bit that starts after the edge. Popping happens
  // from IDLE and on the last cycle of STOP so frames chain without a gap.
  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = w_baudDone ? '0 : r_baud + BAUD_W'(1);
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_parityNext = r_parity;
    w_txNext     = r_tx;
    w_pop        = 1'b0;

    case (r_state)
      IDLE: begin
        w_txNext   = 1'b1;
        w_baudNext = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shiftNext  = w_head;
          w_parityNext = w_headParity;
          w_stateNext  = START;
          w_txNext     = 1'b0;
        end
      end

      START: begin
        if (w_baudDone) begin
          w_stateNext  = DATA;
          w_bitIdxNext = '0;
          w_txNext     = r_shift[0];
        end
      end

      DATA: begin
        if (w_baudDone) begin
          if (r_bitIdx == DATA_LAST) begin
            w_bitIdxNext = '0;
            if (HAS_PARITY) begin
              w_stateNext = PAR;
              w_txNext    = r_parity;
            end else begin
              w_stateNext = STOP;
              w_txNext    = 1'b1;
            end
          end else begin
            w_shiftNext  = r_shift >> 1;
            w_bitIdxNext = r_bitIdx + IDX_W'(1);
            w_txNext     = r_shift[1];
          end
        end
      end

      PAR: begin
        if (w_baudDone) begin
          w_stateNext  = STOP;
          w_bitIdxNext = '0;
          w_txNext     = 1'b1;
        end
      end

      STOP: begin
        if (w_baudDone) begin
          if (r_bitIdx == STOP_LAST) begin
            if (!w_empty) begin
              w_pop        = 1'b1;
              w_shiftNext  = w_head;
              w_parityNext = w_headParity;
              w_stateNext  = START;
              w_txNext     = 1'b0;
            end else begin
              w_stateNext = IDLE;
              w_txNext    = 1'b1;
            end
          end else begin
            w_bitIdxNext = r_bitIdx + IDX_W'(1);
          end
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_txNext    = 1'b1;
        w_baudNext  = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops the line high immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_baud   <= w_baudNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
      r_parity <= w_parityNext;
      r_tx     <= w_txNext;
    end
  end

  assign empty   = w_empty;
  assign busy    = (r_state != IDLE);
  assign UART_TX = r_tx;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Parametrised, FIFO-buffered UART transmitter. It is the next-generation serial output path driving the CPU top level's UART_TX pin. The CPU store path pushes bytes into an internal FIFO without stalling. A frame state machine serialises the bytes with configurable data width, parity and stop bits, and streams back-to-back frames with no idle gap while data is queued.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 2
DATA_BITS, 8, payload bits per frame, range 5..9, sent LSB first
FIFO_DEPTH, 16, FIFO entries; must be a power of 2, >= 2
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  push wr_data into the FIFO this cycle
wr_data  input  DATA_BITS  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky flag: a write was dropped
busy  output  1  FSM not in IDLE
UART_TX  output  1  serial line; idles high

Behaviour:
- Reset (reset=1 at an edge):
  - UART_TX=1, busy=0, empty=1, full=0, count=0, overflow=0.
  - FIFO pointers and baud counter are cleared; FSM goes to IDLE.
  - Reset during a frame aborts it immediately: UART_TX returns high on the next cycle and queued data is discarded.
- FIFO:
  - Write pointer, read pointer and count are registered.
  - A write is accepted when wr_en=1 and full=0.
  - wr_en=1 with full=1 drops the data and sets overflow. overflow stays set until reset.
  - full is evaluated on the pre-edge count. A write while full is dropped even if a pop occurs on the same edge.
  - A simultaneous accepted push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: UART_TX=1. If empty=0 at the edge, pop the head into the shift register, clear the baud counter and go to START.
  - START: UART_TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: UART_TX = shift[0] for CLKS_PER_BIT cycles per bit, shifting right. After DATA_BITS bits, go to PAR if PARITY != 0, else go to STOP.
  - PAR: UART_TX = XOR of the payload (even) or its inverse (odd), for CLKS_PER_BIT cycles. Parity is computed at pop time.
  - STOP: UART_TX=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle: if empty=0, pop and go to START (zero-gap streaming); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - The bit advances when the counter equals CLKS_PER_BIT-1.
- Latency and timing:
  - An accepted write at edge N into an empty FIFO with the FSM idle gives empty=0 after N.
  - The pop occurs at edge N+1, and UART_TX=0 from edge N+1.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles exactly.
- Output registering:
  - UART_TX is registered (no combinational path from wr_en).
  - busy=1 in every state other than IDLE.

Decomposition:
- Shared package uart_pkg:
  - Parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - FSM state encoding localparams.
  - Default CLKS_PER_BIT for the 100 MHz board clock.
- One natural sub-module: sync_fifo. It is parametrised by WIDTH and DEPTH and provides push/pop/full/empty/count. It is reusable for a future UART receiver.
- Serialiser FSM and baud counter stay in uart_tx_buffered.

Test Plan:
1. Reset behaviour: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, reset held for 3 cycles -> UART_TX=1, empty=1, count=0, busy=0, overflow=0.
2. Single frame: write 0x55 at edge N -> UART_TX over 40 cycles from edge N+1 is 0, 1,0,1,0,1,0,1,0, 1 (4 cycles per bit); busy drops after edge N+41.
3. Odd parity with 2 stop bits: write 0x03 (PARITY=2, STOP_BITS=2) -> parity bit = 1, stop high for 8 cycles; frame length is 48 cycles.
4. Back-to-back streaming: write 0xA1, 0xB2, 0xC3 on consecutive cycles -> count peaks at 2; three frames with no idle cycle between the stop bit and the next start bit; empty=1 after the third pop.
5. Overflow: FIFO_DEPTH=4, FSM held off by writing 6 bytes in 6 consecutive cycles. The first byte is popped at cycle 2, so bytes 1–5 are accepted and byte 6 is dropped -> full=1 and overflow=1. The transmitted sequence excludes byte 6. overflow stays 1 until reset.
6. Mid-frame reset: assert reset during bit 3 of 0xFF with 2 bytes queued -> UART_TX=1 on the next cycle, count=0, no further frames are sent.
